// File: rtl/forward_stall_ctrl.sv
// Operand forwarding select, load-use/interlock hazard detection and memory-wait
// stall sequencing for a five-stage pipeline.
module forward_stall_ctrl #(
   parameter int XLEN     = 32,
   parameter int NUM_RS   = 2,
   parameter int FWD_EN   = 1,
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RS*5-1:0]      id_rs,
   input  logic [NUM_RS-1:0]        id_rs_used,
   input  logic [NUM_RS*5-1:0]      ex_rs,
   input  logic [NUM_RS-1:0]        ex_rs_used,
   input  logic [4:0]               ex_rd,
   input  logic                     ex_reg_write,
   input  logic                     ex_mem_read,
   input  logic [4:0]               mem_rd,
   input  logic                     mem_reg_write,
   input  logic [XLEN-1:0]          mem_value,
   input  logic [4:0]               wb_rd,
   input  logic                     wb_reg_write,
   input  logic [XLEN-1:0]          wb_value,
   input  logic                     mem_busy,
   output logic [NUM_RS*2-1:0]      fwd_sel,
   output logic [NUM_RS*XLEN-1:0]   fwd_value,
   output logic                     stall_front,
   output logic                     bubble_ex,
   output logic                     stall_all,
   output logic                     mem_timeout,
   output logic [CNT_W-1:0]         stall_count
);

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      WAIT_MEM = 2'd1,
      TIMEOUT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                load_use_s;
   logic                interlock_s;
   logic                hazard_s;
   logic                mem_hit_s;
   logic                wb_hit_s;

   // Per-port operand forwarding; EX/MEM wins over MEM/WB, x0 is never forwarded
   always_comb begin
      fwd_sel   = '0;
      fwd_value = '0;
      mem_hit_s = 1'b0;
      wb_hit_s  = 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
         mem_hit_s = (FWD_EN != 0) && ex_rs_used[i] && mem_reg_write &&
                     (mem_rd != 5'd0) && (ex_rs[5*i +: 5] == mem_rd);
         wb_hit_s  = (FWD_EN != 0) && ex_rs_used[i] && wb_reg_write &&
                     (wb_rd != 5'd0) && (ex_rs[5*i +: 5] == wb_rd);
         if (mem_hit_s) begin
            fwd_sel[2*i +: 2]         = 2'b01;
            fwd_value[XLEN*i +: XLEN] = mem_value;
         end else if (wb_hit_s) begin
            fwd_sel[2*i +: 2]         = 2'b10;
            fwd_value[XLEN*i +: XLEN] = wb_value;
         end else begin
            fwd_sel[2*i +: 2]         = 2'b00;
            fwd_value[XLEN*i +: XLEN] = '0;
         end
      end
   end

   // Hazard detection; WB is never an interlock source since the register file writes first
   always_comb begin
      load_use_s  = 1'b0;
      interlock_s = 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
         load_use_s  = load_use_s | (id_rs_used[i] && ex_mem_read && ex_reg_write &&
                       (ex_rd != 5'd0) && (id_rs[5*i +: 5] == ex_rd));
         interlock_s = interlock_s | ((FWD_EN == 0) && id_rs_used[i] &&
                       ((ex_reg_write && (ex_rd != 5'd0) && (id_rs[5*i +: 5] == ex_rd)) ||
                        (mem_reg_write && (mem_rd != 5'd0) && (id_rs[5*i +: 5] == mem_rd))));
      end
      hazard_s = load_use_s | interlock_s;
   end

   // Stall FSM next-state and stall outputs; mem_busy is ignored while reset is high
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      stall_all   = 1'b0;
      stall_front = 1'b0;
      bubble_ex   = 1'b0;
      if (reset) begin
         stall_front = hazard_s;
         bubble_ex   = hazard_s;
         state_d     = RUN;
         wait_d      = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_busy) begin
                  stall_all = 1'b1;
                  wait_d    = WAIT_W'(1);
                  state_d   = (MAX_WAIT <= 1) ? TIMEOUT : WAIT_MEM;
               end else begin
                  stall_front = hazard_s;
                  bubble_ex   = hazard_s;
                  wait_d      = '0;
               end
            end
            WAIT_MEM: begin
               if (mem_busy) begin
                  stall_all = 1'b1;
                  wait_d    = wait_q + WAIT_W'(1);
                  if (wait_q >= WAIT_W'(MAX_WAIT - 1)) begin
                     state_d = TIMEOUT;
                  end else begin
                     state_d = WAIT_MEM;
                  end
               end else begin
                  state_d = RUN;
                  wait_d  = '0;
               end
            end
            TIMEOUT: begin
               stall_all = 1'b1;
            end
            default: begin
               state_d = RUN;
               wait_d  = '0;
            end
         endcase
      end
   end

   // Saturating count of stalled cycles
   always_comb begin
      if ((stall_front || stall_all) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State, wait counter and stall counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_timeout = (state_q == TIMEOUT);
   assign stall_count = cnt_q;

endmodule
